// File: rtl/pc_cmd_parser_pkg.sv
// -----------------------------------------------------------------------------
// pc_cmd_parser_pkg
// Shared protocol constants and FSM state encoding for the PC command parser.
//   - Opcode bytes accepted from the host (write / read).
//   - Response bytes returned to the host (ack / bad opcode / bus timeout).
//   - state_t: parser FSM states, also exported on the debug state output.
// -----------------------------------------------------------------------------
package pc_cmd_parser_pkg;

   localparam logic [7:0] OP_WRITE  = 8'h57;  // 'W'
   localparam logic [7:0] OP_READ   = 8'h52;  // 'R'
   localparam logic [7:0] RSP_ACK   = 8'h4B;  // write completed
   localparam logic [7:0] RSP_BADOP = 8'h3F;  // unknown opcode
   localparam logic [7:0] RSP_BUSTO = 8'h21;  // bus access never started

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_ADDR      = 3'd1,
      ST_SEL       = 3'd2,
      ST_DATA      = 3'd3,
      ST_START     = 3'd4,
      ST_WAIT_ACT  = 3'd5,
      ST_WAIT_DONE = 3'd6,
      ST_RESP      = 3'd7
   } state_t;

   function automatic logic is_valid_op(input logic [7:0] b);
      return (b == OP_WRITE) || (b == OP_READ);
   endfunction

endpackage

// File: rtl/pc_cmd_parser_if.sv
// -----------------------------------------------------------------------------
// pc_cmd_parser_if
// Groups every non-clock/reset signal of the command parser.
//   UART RX side : rx_valid, rx_data
//   UART TX side : tx_data, tx_valid, tx_ready
//   cpu_top side : cpu_start, cpu_address, cpu_selection, cpu_write,
//                  cpu_data_wr, cpu_data_rd, cpu_active
//   status       : busy, frame_err, state_dbg (current FSM state)
// Handshake: a TX byte transfers on a cycle where tx_valid && tx_ready are
// both high; while tx_valid is high and tx_ready low, tx_data holds steady.
// rx_valid is a one-cycle strobe with no back-pressure.
// Modports: master = parser, slave = surrounding UART/cpu_top environment.
// -----------------------------------------------------------------------------
interface pc_cmd_parser_if;
   import pc_cmd_parser_pkg::*;

   logic        rx_valid;
   logic [7:0]  rx_data;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic        cpu_start;
   logic [31:0] cpu_address;
   logic [3:0]  cpu_selection;
   logic        cpu_write;
   logic [31:0] cpu_data_wr;
   logic [31:0] cpu_data_rd;
   logic        cpu_active;
   logic        busy;
   logic        frame_err;
   state_t      state_dbg;

   modport master (
      input  rx_valid, rx_data, tx_ready, cpu_data_rd, cpu_active,
      output tx_data, tx_valid, cpu_start, cpu_address, cpu_selection,
             cpu_write, cpu_data_wr, busy, frame_err, state_dbg
   );

   modport slave (
      output rx_valid, rx_data, tx_ready, cpu_data_rd, cpu_active,
      input  tx_data, tx_valid, cpu_start, cpu_address, cpu_selection,
             cpu_write, cpu_data_wr, busy, frame_err, state_dbg
   );

endinterface

// File: rtl/pc_cmd_parser_resp_serializer.sv
// -----------------------------------------------------------------------------
// pc_resp_serializer
// Serialises a 1- or 4-byte response onto the UART TX handshake.
//   clk, rst   : clock, synchronous active-high reset
//   load       : capture word and start sending (ignored bytes are dropped)
//   four       : 1 = send word[31:0] MSB first, 0 = send word[7:0] only
//   word       : response payload
//   tx_ready   : UART accepts tx_data this cycle
//   tx_valid   : tx_data valid, held until accepted
//   tx_data    : byte being offered
//   done       : high in the cycle the final byte transfers
// -----------------------------------------------------------------------------
module pc_resp_serializer (
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic        four,
   input  logic [31:0] word,
   input  logic        tx_ready,
   output logic        tx_valid,
   output logic [7:0]  tx_data,
   output logic        done
);

   logic [31:0] sh_q, sh_d;
   logic [2:0]  rem_q, rem_d;
   logic        valid_q, valid_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         sh_q    <= '0;
         rem_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         sh_q    <= sh_d;
         rem_q   <= rem_d;
         valid_q <= valid_d;
      end
   end

   always_comb begin
      sh_d    = sh_q;
      rem_d   = rem_q;
      valid_d = valid_q;
      done    = 1'b0;
      if (valid_q && tx_ready) begin
         // Next byte moves into the top lane, so it is offered the next cycle.
         sh_d  = {sh_q[23:0], 8'h00};
         rem_d = rem_q - 3'd1;
         if (rem_q == 3'd1) begin
            valid_d = 1'b0;
            done    = 1'b1;
         end
      end
      if (load) begin
         // Single-byte responses are parked in the top lane too.
         sh_d    = four ? word : {word[7:0], 24'h000000};
         rem_d   = four ? 3'd4 : 3'd1;
         valid_d = 1'b1;
      end
   end

   assign tx_valid = valid_q;
   assign tx_data  = sh_q[31:24];

endmodule

// File: rtl/pc_cmd_parser.sv
// -----------------------------------------------------------------------------
// pc_cmd_parser
// Byte-level command decoder between the UART core and cpu_top. Assembles
// write ('W' addr[4] sel data[4]) and read ('R' addr[4] sel) frames, launches
// one access through cpu_top, waits for it to finish and returns a response
// (0x4B for writes, four data bytes MSB first for reads).
//   wb_clk, wb_rst : clock, synchronous active-high reset
//   bus (master)   : UART RX/TX, cpu_top command/status, busy, frame_err,
//                    state_dbg
// Errors: unknown opcode -> 0x3F; inter-byte timeout -> silent return to
// IDLE; cpu_active never rising -> 0x21. Each pulses frame_err once.
// -----------------------------------------------------------------------------
module pc_cmd_parser
   import pc_cmd_parser_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
   input  logic            wb_clk,
   input  logic            wb_rst,
   pc_cmd_parser_if.master bus
);

   localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

   state_t         state_q, state_d;
   logic [1:0]     byte_cnt_q, byte_cnt_d;
   logic [CW-1:0]  tmo_cnt_q, tmo_cnt_d;
   logic [31:0]    addr_q, addr_d;
   logic [3:0]     sel_q, sel_d;
   logic           wr_q, wr_d;
   logic [31:0]    data_q, data_d;

   logic           ser_load;
   logic           ser_four;
   logic [31:0]    ser_word;
   logic           ser_done;
   logic           frame_err_c;
   logic           tmo_hit;

   always_ff @(posedge wb_clk) begin
      if (wb_rst) begin
         state_q    <= ST_IDLE;
         byte_cnt_q <= '0;
         tmo_cnt_q  <= '0;
         addr_q     <= '0;
         sel_q      <= '0;
         wr_q       <= 1'b0;
         data_q     <= '0;
      end else begin
         state_q    <= state_d;
         byte_cnt_q <= byte_cnt_d;
         tmo_cnt_q  <= tmo_cnt_d;
         addr_q     <= addr_d;
         sel_q      <= sel_d;
         wr_q       <= wr_d;
         data_q     <= data_d;
      end
   end

   assign tmo_hit = (tmo_cnt_q == TMO_LAST);

   always_comb begin
      state_d     = state_q;
      byte_cnt_d  = byte_cnt_q;
      tmo_cnt_d   = tmo_cnt_q;
      addr_d      = addr_q;
      sel_d       = sel_q;
      wr_d        = wr_q;
      data_d      = data_q;
      ser_load    = 1'b0;
      ser_four    = 1'b0;
      ser_word    = '0;
      frame_err_c = 1'b0;

      case (state_q)
         ST_IDLE: begin
            byte_cnt_d = '0;
            tmo_cnt_d  = '0;
            if (bus.rx_valid) begin
               if (is_valid_op(bus.rx_data)) begin
                  wr_d    = (bus.rx_data == OP_WRITE);
                  state_d = ST_ADDR;
               end else begin
                  ser_load    = 1'b1;
                  ser_word    = {24'h000000, RSP_BADOP};
                  frame_err_c = 1'b1;
                  state_d     = ST_RESP;
               end
            end
         end

         // In the three frame-body states a byte arriving in the terminal
         // count cycle is taken and the timeout is abandoned.
         ST_ADDR: begin
            if (bus.rx_valid) begin
               addr_d     = {addr_q[23:0], bus.rx_data};
               tmo_cnt_d  = '0;
               byte_cnt_d = byte_cnt_q + 2'd1;
               if (byte_cnt_q == 2'd3) state_d = ST_SEL;
            end else if (tmo_hit) begin
               frame_err_c = 1'b1;
               state_d     = ST_IDLE;
            end else begin
               tmo_cnt_d = tmo_cnt_q + CW'(1);
            end
         end

         ST_SEL: begin
            if (bus.rx_valid) begin
               sel_d     = bus.rx_data[3:0];
               tmo_cnt_d = '0;
               state_d   = wr_q ? ST_DATA : ST_START;
            end else if (tmo_hit) begin
               frame_err_c = 1'b1;
               state_d     = ST_IDLE;
            end else begin
               tmo_cnt_d = tmo_cnt_q + CW'(1);
            end
         end

         ST_DATA: begin
            if (bus.rx_valid) begin
               data_d     = {data_q[23:0], bus.rx_data};
               tmo_cnt_d  = '0;
               byte_cnt_d = byte_cnt_q + 2'd1;
               if (byte_cnt_q == 2'd3) state_d = ST_START;
            end else if (tmo_hit) begin
               frame_err_c = 1'b1;
               state_d     = ST_IDLE;
            end else begin
               tmo_cnt_d = tmo_cnt_q + CW'(1);
            end
         end

         ST_START: begin
            tmo_cnt_d = '0;
            state_d   = ST_WAIT_ACT;
         end

         ST_WAIT_ACT: begin
            if (bus.cpu_active) begin
               state_d = ST_WAIT_DONE;
            end else if (tmo_hit) begin
               ser_load    = 1'b1;
               ser_word    = {24'h000000, RSP_BUSTO};
               frame_err_c = 1'b1;
               state_d     = ST_RESP;
            end else begin
               tmo_cnt_d = tmo_cnt_q + CW'(1);
            end
         end

         ST_WAIT_DONE: begin
            // Read data is captured by the serializer on this same edge.
            if (!bus.cpu_active) begin
               ser_load = 1'b1;
               if (wr_q) begin
                  ser_word = {24'h000000, RSP_ACK};
               end else begin
                  ser_word = bus.cpu_data_rd;
                  ser_four = 1'b1;
               end
               state_d = ST_RESP;
            end
         end

         ST_RESP: begin
            if (ser_done) state_d = ST_IDLE;
         end

         default: state_d = ST_IDLE;
      endcase
   end

   pc_resp_serializer u_ser (
      .clk      (wb_clk),
      .rst      (wb_rst),
      .load     (ser_load),
      .four     (ser_four),
      .word     (ser_word),
      .tx_ready (bus.tx_ready),
      .tx_valid (bus.tx_valid),
      .tx_data  (bus.tx_data),
      .done     (ser_done)
   );

   assign bus.cpu_start     = (state_q == ST_START);
   assign bus.cpu_address   = addr_q;
   assign bus.cpu_selection = sel_q;
   assign bus.cpu_write     = wr_q;
   assign bus.cpu_data_wr   = data_q;
   assign bus.busy          = (state_q != ST_IDLE);
   assign bus.frame_err     = frame_err_c;
   assign bus.state_dbg     = state_q;

endmodule

// File: tb/tb_pc_cmd_parser.sv
// -----------------------------------------------------------------------------
// tb_pc_cmd_parser
// Directed bench for pc_cmd_parser with TIMEOUT_CYCLES = 16. Inputs are driven
// 1 time unit after the rising edge; a monitor on the rising edge records
// accepted TX bytes, cpu_start pulses, frame_err pulses and tx_data changes
// while stalled.
// -----------------------------------------------------------------------------
module tb_pc_cmd_parser;
   import pc_cmd_parser_pkg::*;

   localparam int TMO = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   pc_cmd_parser_if bus();

   pc_cmd_parser #(.TIMEOUT_CYCLES(TMO)) dut (
      .wb_clk (clk),
      .wb_rst (rst),
      .bus    (bus)
   );

   int pass_cnt  = 0;
   int total_cnt = 0;

   // ---------------- monitor ----------------
   logic [7:0] tx_q[$];
   int         start_cnt  = 0;
   int         ferr_cnt   = 0;
   int         stall_err  = 0;
   logic       prev_stall = 1'b0;
   logic [7:0] prev_data  = 8'h00;

   always @(posedge clk) begin
      if (rst) begin
         prev_stall = 1'b0;
      end else begin
         if (bus.tx_valid && bus.tx_ready) tx_q.push_back(bus.tx_data);
         if (bus.cpu_start) start_cnt++;
         if (bus.frame_err) ferr_cnt++;
         if (prev_stall && bus.tx_data !== prev_data) stall_err++;
         prev_stall = bus.tx_valid && !bus.tx_ready;
         prev_data  = bus.tx_data;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", pass_cnt, total_cnt);
      $fatal(1, "watchdog");
   end

   // ---------------- driver tasks ----------------
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      bus.rx_data  = b;
      bus.rx_valid = 1'b1;
      tick(1);
      bus.rx_valid = 1'b0;
   endtask

   task automatic send_frame(input logic wr, input logic [31:0] addr,
                             input logic [7:0] sel, input logic [31:0] data);
      send_byte(wr ? OP_WRITE : OP_READ);
      for (int i = 3; i >= 0; i--) send_byte(addr[8*i +: 8]);
      send_byte(sel);
      if (wr) for (int i = 3; i >= 0; i--) send_byte(data[8*i +: 8]);
   endtask

   // Called in the START cycle; cpu_active high for act_cycles, rd presented
   // only in the cycle cpu_active falls.
   task automatic cpu_respond(input int act_cycles, input logic [31:0] rd);
      tick(1);
      bus.cpu_active = 1'b1;
      tick(act_cycles);
      bus.cpu_data_rd = rd;
      bus.cpu_active  = 1'b0;
      tick(1);
      bus.cpu_data_rd = 32'hA5A5_A5A5;
   endtask

   task automatic wait_tx(input int n, input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (tx_q.size() >= n) begin
            ok = 1'b1;
            break;
         end
         tick(1);
      end
      if (tx_q.size() >= n) ok = 1'b1;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b1;
      tick(3);
      rst = 1'b0;
      tick(1);
      total_cnt++; if (bus.tx_valid !== 1'b0) $display("FAIL reset_tx_valid: got %b want 0", bus.tx_valid); else pass_cnt++;
      total_cnt++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.busy); else pass_cnt++;
      total_cnt++; if (bus.cpu_start !== 1'b0) $display("FAIL reset_cpu_start: got %b want 0", bus.cpu_start); else pass_cnt++;
      total_cnt++; if (bus.cpu_address !== 32'h0) $display("FAIL reset_cpu_address: got %h want 0", bus.cpu_address); else pass_cnt++;
      total_cnt++; if (bus.frame_err !== 1'b0) $display("FAIL reset_frame_err: got %b want 0", bus.frame_err); else pass_cnt++;
      total_cnt++; if (bus.state_dbg !== ST_IDLE) $display("FAIL reset_state: got %0d want %0d", bus.state_dbg, ST_IDLE); else pass_cnt++;
   endtask

   task automatic test_write();
      int s0;
      bit ok;
      logic [7:0] got;
      s0 = start_cnt;
      tx_q.delete();
      bus.tx_ready = 1'b1;
      send_frame(1'b1, 32'h0000_1004, 8'h0F, 32'hDEAD_BEEF);
      total_cnt++; if (bus.cpu_start !== 1'b1) $display("FAIL wr_start_latency: got %b want 1", bus.cpu_start); else pass_cnt++;
      total_cnt++; if (bus.cpu_address !== 32'h0000_1004) $display("FAIL wr_address: got %h want 00001004", bus.cpu_address); else pass_cnt++;
      total_cnt++; if (bus.cpu_selection !== 4'hF) $display("FAIL wr_sel: got %h want f", bus.cpu_selection); else pass_cnt++;
      total_cnt++; if (bus.cpu_write !== 1'b1) $display("FAIL wr_write: got %b want 1", bus.cpu_write); else pass_cnt++;
      total_cnt++; if (bus.cpu_data_wr !== 32'hDEAD_BEEF) $display("FAIL wr_data: got %h want deadbeef", bus.cpu_data_wr); else pass_cnt++;
      cpu_respond(3, 32'h0);
      wait_tx(1, 20, ok);
      got = (tx_q.size() > 0) ? tx_q[0] : 8'hxx;
      total_cnt++; if (!ok || got !== RSP_ACK) $display("FAIL wr_ack: got %h (ok=%0b) want 4b", got, ok); else pass_cnt++;
      total_cnt++; if (bus.tx_valid !== 1'b0 || bus.busy !== 1'b0) $display("FAIL wr_end_idle: got tx_valid=%b busy=%b want 0 0", bus.tx_valid, bus.busy); else pass_cnt++;
      total_cnt++; if (start_cnt - s0 !== 1) $display("FAIL wr_start_count: got %0d want 1", start_cnt - s0); else pass_cnt++;
      tick(2);
      total_cnt++; if (tx_q.size() !== 1) $display("FAIL wr_tx_count: got %0d want 1", tx_q.size()); else pass_cnt++;
      total_cnt++; if (bus.cpu_address !== 32'h0000_1004) $display("FAIL wr_address_hold: got %h want 00001004", bus.cpu_address); else pass_cnt++;
   endtask

   task automatic test_read_throttled();
      logic [31:0] got;
      int cyc;
      tx_q.delete();
      bus.tx_ready = 1'b0;
      send_frame(1'b0, 32'h0000_2000, 8'h0F, 32'h0);
      total_cnt++; if (bus.cpu_start !== 1'b1 || bus.cpu_write !== 1'b0) $display("FAIL rd_start: got start=%b write=%b want 1 0", bus.cpu_start, bus.cpu_write); else pass_cnt++;
      total_cnt++; if (bus.cpu_address !== 32'h0000_2000) $display("FAIL rd_address: got %h want 00002000", bus.cpu_address); else pass_cnt++;
      cpu_respond(2, 32'h1234_5678);
      cyc = 0;
      while (tx_q.size() < 4 && cyc < 60) begin
         bus.tx_ready = ((cyc % 3) == 2);
         tick(1);
         cyc++;
      end
      total_cnt++; if (tx_q.size() !== 4) $display("FAIL rd_byte_count: got %0d want 4", tx_q.size()); else pass_cnt++;
      got = (tx_q.size() >= 4) ? {tx_q[0], tx_q[1], tx_q[2], tx_q[3]} : 32'hxxxx_xxxx;
      total_cnt++; if (got !== 32'h1234_5678) $display("FAIL rd_bytes: got %h want 12345678", got); else pass_cnt++;
      total_cnt++; if (stall_err !== 0) $display("FAIL rd_stall_stable: got %0d changes want 0", stall_err); else pass_cnt++;
      total_cnt++; if (bus.tx_valid !== 1'b0 || bus.busy !== 1'b0) $display("FAIL rd_end_idle: got tx_valid=%b busy=%b want 0 0", bus.tx_valid, bus.busy); else pass_cnt++;
      bus.tx_ready = 1'b1;
   endtask

   task automatic test_bad_opcode();
      int s0, f0;
      bit ok;
      logic [7:0] got;
      s0 = start_cnt;
      f0 = ferr_cnt;
      tx_q.delete();
      bus.tx_ready = 1'b1;
      send_byte(8'h41);
      total_cnt++; if (bus.tx_valid !== 1'b1 || bus.tx_data !== RSP_BADOP) $display("FAIL badop_present: got v=%b d=%h want 1 3f", bus.tx_valid, bus.tx_data); else pass_cnt++;
      wait_tx(1, 10, ok);
      got = (tx_q.size() > 0) ? tx_q[0] : 8'hxx;
      total_cnt++; if (!ok || got !== RSP_BADOP) $display("FAIL badop_resp: got %h want 3f", got); else pass_cnt++;
      total_cnt++; if (ferr_cnt - f0 !== 1) $display("FAIL badop_ferr: got %0d want 1", ferr_cnt - f0); else pass_cnt++;
      total_cnt++; if (start_cnt - s0 !== 0 || bus.busy !== 1'b0) $display("FAIL badop_nostart: got starts=%0d busy=%b want 0 0", start_cnt - s0, bus.busy); else pass_cnt++;
      tx_q.delete();
      send_frame(1'b1, 32'hCAFE_0010, 8'h53, 32'h0102_0304);
      total_cnt++; if (bus.cpu_start !== 1'b1 || bus.cpu_address !== 32'hCAFE_0010) $display("FAIL badop_next_start: got start=%b addr=%h want 1 cafe0010", bus.cpu_start, bus.cpu_address); else pass_cnt++;
      total_cnt++; if (bus.cpu_selection !== 4'h3) $display("FAIL badop_next_sel_nibble: got %h want 3", bus.cpu_selection); else pass_cnt++;
      cpu_respond(1, 32'h0);
      wait_tx(1, 20, ok);
      got = (tx_q.size() > 0) ? tx_q[0] : 8'hxx;
      total_cnt++; if (!ok || got !== RSP_ACK) $display("FAIL badop_next_ack: got %h want 4b", got); else pass_cnt++;
   endtask

   task automatic test_byte_timeout();
      int s0, f0;
      bit ok;
      logic [7:0] got;
      s0 = start_cnt;
      f0 = ferr_cnt;
      tx_q.delete();
      send_byte(OP_WRITE);
      send_byte(8'h00);
      send_byte(8'h00);
      tick(14);
      total_cnt++; if (bus.frame_err !== 1'b0 || bus.busy !== 1'b1) $display("FAIL tmo_cycle14: got ferr=%b busy=%b want 0 1", bus.frame_err, bus.busy); else pass_cnt++;
      tick(1);
      total_cnt++; if (bus.frame_err !== 1'b1) $display("FAIL tmo_cycle15_ferr: got %b want 1", bus.frame_err); else pass_cnt++;
      tick(1);
      total_cnt++; if (bus.busy !== 1'b0 || bus.state_dbg !== ST_IDLE) $display("FAIL tmo_idle: got busy=%b state=%0d want 0 0", bus.busy, bus.state_dbg); else pass_cnt++;
      total_cnt++; if (ferr_cnt - f0 !== 1 || start_cnt - s0 !== 0) $display("FAIL tmo_counts: got ferr=%0d starts=%0d want 1 0", ferr_cnt - f0, start_cnt - s0); else pass_cnt++;
      tick(4);
      total_cnt++; if (tx_q.size() !== 0 || bus.tx_valid !== 1'b0) $display("FAIL tmo_no_resp: got bytes=%0d tx_valid=%b want 0 0", tx_q.size(), bus.tx_valid); else pass_cnt++;

      // Byte landing exactly on the terminal-count cycle keeps the frame alive.
      f0 = ferr_cnt;
      send_byte(OP_WRITE);
      send_byte(8'h00);
      send_byte(8'h00);
      tick(15);
      bus.rx_data  = 8'h30;
      bus.rx_valid = 1'b1;
      #1;
      total_cnt++; if (bus.frame_err !== 1'b0) $display("FAIL tmo_edge_byte_ferr: got %b want 0", bus.frame_err); else pass_cnt++;
      tick(1);
      bus.rx_valid = 1'b0;
      send_byte(8'h04);
      send_byte(8'h0F);
      for (int i = 3; i >= 0; i--) begin
         logic [31:0] d;
         d = 32'h1122_3344;
         send_byte(d[8*i +: 8]);
      end
      total_cnt++; if (bus.cpu_start !== 1'b1 || bus.cpu_address !== 32'h0000_3004) $display("FAIL tmo_edge_start: got start=%b addr=%h want 1 00003004", bus.cpu_start, bus.cpu_address); else pass_cnt++;
      total_cnt++; if (bus.cpu_data_wr !== 32'h1122_3344) $display("FAIL tmo_edge_data: got %h want 11223344", bus.cpu_data_wr); else pass_cnt++;
      cpu_respond(1, 32'h0);
      wait_tx(1, 20, ok);
      got = (tx_q.size() > 0) ? tx_q[0] : 8'hxx;
      total_cnt++; if (!ok || got !== RSP_ACK || ferr_cnt - f0 !== 0) $display("FAIL tmo_edge_ack: got %h ferr=%0d want 4b 0", got, ferr_cnt - f0); else pass_cnt++;
   endtask

   task automatic test_bus_timeout();
      int f0;
      bit ok;
      logic [7:0] got;
      f0 = ferr_cnt;
      tx_q.delete();
      send_frame(1'b0, 32'h0000_0040, 8'h0F, 32'h0);
      tick(1);
      tick(14);
      total_cnt++; if (bus.frame_err !== 1'b0 || bus.state_dbg !== ST_WAIT_ACT) $display("FAIL busto_cycle14: got ferr=%b state=%0d want 0 %0d", bus.frame_err, bus.state_dbg, ST_WAIT_ACT); else pass_cnt++;
      tick(1);
      total_cnt++; if (bus.frame_err !== 1'b1) $display("FAIL busto_ferr: got %b want 1", bus.frame_err); else pass_cnt++;
      wait_tx(1, 10, ok);
      got = (tx_q.size() > 0) ? tx_q[0] : 8'hxx;
      total_cnt++; if (!ok || got !== RSP_BUSTO) $display("FAIL busto_resp: got %h want 21", got); else pass_cnt++;
      total_cnt++; if (bus.busy !== 1'b0 || ferr_cnt - f0 !== 1) $display("FAIL busto_end: got busy=%b ferr=%0d want 0 1", bus.busy, ferr_cnt - f0); else pass_cnt++;
   endtask

   task automatic test_reset_mid_resp();
      logic [15:0] got;
      tx_q.delete();
      bus.tx_ready = 1'b0;
      send_frame(1'b0, 32'h0000_0080, 8'h0F, 32'h0);
      cpu_respond(1, 32'hCAFE_F00D);
      total_cnt++; if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'hCA) $display("FAIL rstmid_first: got v=%b d=%h want 1 ca", bus.tx_valid, bus.tx_data); else pass_cnt++;
      bus.tx_ready = 1'b1;
      tick(2);
      rst = 1'b1;
      tick(1);
      total_cnt++; if (bus.tx_valid !== 1'b0 || bus.busy !== 1'b0) $display("FAIL rstmid_drop: got tx_valid=%b busy=%b want 0 0", bus.tx_valid, bus.busy); else pass_cnt++;
      rst = 1'b0;
      tick(8);
      got = (tx_q.size() >= 2) ? {tx_q[0], tx_q[1]} : 16'hxxxx;
      total_cnt++; if (tx_q.size() !== 2 || got !== 16'hCAFE) $display("FAIL rstmid_bytes: got n=%0d %h want 2 cafe", tx_q.size(), got); else pass_cnt++;
   endtask

   initial begin
      bus.rx_valid    = 1'b0;
      bus.rx_data     = 8'h00;
      bus.tx_ready    = 1'b0;
      bus.cpu_data_rd = 32'h0;
      bus.cpu_active  = 1'b0;
      test_reset();
      test_write();
      test_read_throttled();
      test_bad_opcode();
      test_byte_timeout();
      test_bus_timeout();
      test_reset_mid_resp();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
